// File: rtl/core_pkg.sv
// Shared core constants: datapath width, register index width and ctrl-bit positions.
package core_pkg;
  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage slot: valid bit plus payload, ctrl and rd fields.
module pipe_entry
  import core_pkg::*;
#(
  parameter int DATA_W = 2 * XLEN,
  parameter int CTRL_W = 2,
  parameter int RD_W   = REG_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [RD_W-1:0]   rd_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  // Clearing zeroes ctrl/rd so an empty slot reads as a bubble; payload is left stale.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd_d    = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
      rd_d    = rd_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
  assign rd_o    = rd_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with optional skid slot for a registered in_ready.
module pipe_stage_skid
  import core_pkg::*;
#(
  parameter int DATA_W = 2 * XLEN,
  parameter int CTRL_W = 2,
  parameter int RD_W   = REG_ADDR_W,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);
  logic              head_v, skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [RD_W-1:0]   skid_rd;
  logic              accept, drain;
  logic              head_load, head_clear, head_from_skid;
  logic [DATA_W-1:0] head_data_in;
  logic [CTRL_W-1:0] head_ctrl_in;
  logic [RD_W-1:0]   head_rd_in;

  assign accept = in_valid & in_ready;
  assign drain  = head_v & out_ready;

  // The skid entry is always older than a new accept, so it has priority into the head.
  always_comb begin
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      head_clear = 1'b1;
    end else if (!head_v) begin
      head_load = accept;
    end else if (drain) begin
      if (skid_v) begin
        head_load      = 1'b1;
        head_from_skid = 1'b1;
      end else if (accept) begin
        head_load = 1'b1;
      end else begin
        head_clear = 1'b1;
      end
    end
  end

  assign head_data_in = head_from_skid ? skid_data : in_data;
  assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_rd_in   = head_from_skid ? skid_rd   : in_rd;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_head (
    .clock   (clock),
    .reset   (reset),
    .load_i  (head_load),
    .clear_i (head_clear),
    .data_i  (head_data_in),
    .ctrl_i  (head_ctrl_in),
    .rd_i    (head_rd_in),
    .valid_o (head_v),
    .data_o  (out_data),
    .ctrl_o  (out_ctrl),
    .rd_o    (out_rd)
  );

  generate
    if (SKID != 0) begin : gen_skid
      logic skid_load, skid_clear;
      // Skid fills only when the head is stuck; in_ready=~skid_v guarantees it is free then.
      assign skid_load  = ~flush & accept & head_v & ~drain;
      assign skid_clear = flush | (drain & skid_v);
      assign in_ready   = ~skid_v;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .rd_i    (in_rd),
        .valid_o (skid_v),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl),
        .rd_o    (skid_rd)
      );
    end else begin : gen_noskid
      assign skid_v    = 1'b0;
      assign skid_data = '0;
      assign skid_ctrl = '0;
      assign skid_rd   = '0;
      assign in_ready  = ~head_v | out_ready;
    end
  endgenerate

  assign out_valid = head_v;
  assign occupancy = occ_count(head_v, skid_v);
endmodule
